ws2812_multi_ctrl: RTL

//  APB-mapped multi-channel WS2812 LED string driver; next generation of the single-string WS2812 peripheral.
//  NUM_CH serial outputs are driven in parallel from a shared per-channel colour buffer with common bit timing.

---
 rtl/ws2812_multi_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_multi_ctrl.sv
// ws2812_multi_ctrl
//   APB-mapped driver for NUM_CH WS2812 LED strings. Every string is
//   clocked out in parallel with the same bit timing. Each string reads
//   from its own slice of a shared colour buffer.
//
//   Ports
//     clk_i, reset_i           clock; asynchronous active-high reset
//     apb_psel_i .. apb_pwdata_i  APB slave inputs (6-bit byte address)
//     apb_prdata_o, apb_pready_o, apb_pslverr_o  APB slave outputs (no wait states)
//     led_ctl_o[NUM_CH]        serial data, one bit per string
//     int_o                    frame-done interrupt (level, done & irq_en)
//
//   Register map: 0x00 STATUS, 0x04 CONTROL, 0x08 ADDR, 0x0C COLOUR_WR,
//                 0x10 COLOUR_RD, 0x14 LED_CNT
//
//   Optional build macro WS2812_DOUBLE_BUF_EN selects double buffering.
//   APB then accesses a back bank. The back bank is copied into the
//   front (serialiser) bank when a frame starts.
module ws2812_multi_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int NUM_LEDS    = 64,
  parameter int COLOUR_BITS = 24,
  parameter int T0H_CYC     = 20,
  parameter int T1H_CYC     = 40,
  parameter int BIT_CYC     = 63,
  parameter int LATCH_CYC   = 2500
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              apb_psel_i,
  input  logic              apb_penable_i,
  input  logic              apb_pwrite_i,
  input  logic [5:0]        apb_paddr_i,
  input  logic [31:0]       apb_pwdata_i,
  output logic [31:0]       apb_prdata_o,
  output logic              apb_pready_o,
  output logic              apb_pslverr_o,
  output logic [NUM_CH-1:0] led_ctl_o,
  output logic              int_o
);
  localparam int CW = $clog2(LATCH_CYC + BIT_CYC + 1);
  localparam int BW = $clog2(COLOUR_BITS);
  localparam logic [CW-1:0] T0H_C       = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_C       = CW'(T1H_CYC);
  localparam logic [CW-1:0] BIT_LAST    = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] BIT_PRELOAD = CW'(BIT_CYC - 2);
  localparam logic [CW-1:0] LATCH_LAST  = CW'(LATCH_CYC - 1);
  localparam logic [BW-1:0] BIT_IDX_LAST = BW'(COLOUR_BITS - 1);
  localparam logic [8:0]    NUM_LEDS_C  = 9'(NUM_LEDS);
  localparam logic [4:0]    NUM_CH_C    = 5'(NUM_CH);
  localparam logic [5:0] A_STATUS = 6'h00, A_CTRL = 6'h04, A_ADDR = 6'h08,
                         A_CWR = 6'h0C, A_CRD = 6'h10, A_LCNT = 6'h14;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_HIGH, ST_LOW, ST_LATCH} state_t;

  state_t                 state_reg;
  logic [CW-1:0]          cyc_reg;
  logic [BW-1:0]          bit_reg;
  logic [7:0]             led_num_reg;
  logic [NUM_CH-1:0]      led_reg;
  logic                   sending_reg, done_reg, dirty_reg, int_reg;
  logic [COLOUR_BITS-1:0] shift_reg [NUM_CH];
  logic                   auto_send_reg, irq_en_reg;
  logic [7:0]             led_idx_reg;
  logic [3:0]             ch_idx_reg;
  logic [8:0]             led_cnt_reg;

  logic [COLOUR_BITS-1:0] apb_mem   [NUM_CH][NUM_LEDS];
  logic [COLOUR_BITS-1:0] frame_mem [NUM_CH][NUM_LEDS];
  logic [COLOUR_BITS-1:0] rd_colour;
  logic [COLOUR_BITS-1:0] load_val [NUM_CH];

  logic access, wr_en, rd_en, mapped, colour_oob, cnt_bad, err;
  logic colour_wr_ok, send_wr, start_frame;
  logic [8:0] led_inc;
  logic unused_pwdata;

  // APB decode: zero wait states, so every access phase completes at once.
  assign access       = apb_psel_i & apb_penable_i;
  assign wr_en        = access & apb_pwrite_i;
  assign rd_en        = access & ~apb_pwrite_i;
  assign mapped       = (apb_paddr_i == A_STATUS) | (apb_paddr_i == A_CTRL) |
                        (apb_paddr_i == A_ADDR)   | (apb_paddr_i == A_CWR)  |
                        (apb_paddr_i == A_CRD)    | (apb_paddr_i == A_LCNT);
  assign colour_oob   = ({1'b0, ch_idx_reg} >= NUM_CH_C) | ({1'b0, led_idx_reg} >= NUM_LEDS_C);
  assign cnt_bad      = (apb_pwdata_i[8:0] == 9'd0) | (apb_pwdata_i[8:0] > NUM_LEDS_C);
  assign err          = access & (~mapped |
                        (((apb_paddr_i == A_CWR) | (apb_paddr_i == A_CRD)) & colour_oob) |
                        (apb_pwrite_i & (apb_paddr_i == A_LCNT) & cnt_bad));
  assign colour_wr_ok = wr_en & (apb_paddr_i == A_CWR) & ~colour_oob;
  assign send_wr      = wr_en & (apb_paddr_i == A_CTRL) & apb_pwdata_i[1];
  assign start_frame  = (state_reg == ST_IDLE) & (send_wr | (auto_send_reg & dirty_reg));
  assign led_inc      = {1'b0, led_idx_reg} + 9'd1;
  assign unused_pwdata = &{1'b0, apb_pwdata_i};

  assign apb_pready_o  = access;
  assign apb_pslverr_o = err;
  assign led_ctl_o     = led_reg;
  assign int_o         = int_reg;

  // Colour storage: one register per (channel, LED) cell.
  // The cells are asynchronously cleared by reset.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    for (genvar gj = 0; gj < NUM_LEDS; gj++) begin : g_led
      logic [COLOUR_BITS-1:0] back_reg;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
          back_reg <= '0;
        else if (colour_wr_ok && ch_idx_reg == 4'(gi) && led_idx_reg == 8'(gj))
          back_reg <= apb_pwdata_i[COLOUR_BITS-1:0];
      end
      assign apb_mem[gi][gj] = back_reg;
`ifdef WS2812_DOUBLE_BUF_EN
      // Front bank takes a snapshot at frame start.
      // The frame therefore never shows a half-written update.
      logic [COLOUR_BITS-1:0] front_reg;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
          front_reg <= '0;
        else if (start_frame)
          front_reg <= back_reg;
      end
      assign frame_mem[gi][gj] = front_reg;
`else
      assign frame_mem[gi][gj] = back_reg;
`endif
    end
  end

  always_comb begin
    rd_colour = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      load_val[c] = '0;
      for (int l = 0; l < NUM_LEDS; l++) begin
        if (ch_idx_reg == 4'(c) && led_idx_reg == 8'(l)) rd_colour = apb_mem[c][l];
        if (led_num_reg == 8'(l)) load_val[c] = frame_mem[c][l];
      end
    end
  end

  always_comb begin
    apb_prdata_o = '0;
    if (rd_en && !err) begin
      case (apb_paddr_i)
        A_STATUS: apb_prdata_o = {30'd0, done_reg, sending_reg};
        A_CTRL:   apb_prdata_o = {29'd0, irq_en_reg, 1'b0, auto_send_reg};
        A_ADDR:   apb_prdata_o = {20'd0, ch_idx_reg, led_idx_reg};
        A_CRD:    apb_prdata_o = 32'(rd_colour);
        A_LCNT:   apb_prdata_o = {23'd0, led_cnt_reg};
        default:  apb_prdata_o = '0;
      endcase
    end
  end

  // Software-visible configuration and the colour access pointer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      auto_send_reg <= 1'b0;
      irq_en_reg    <= 1'b0;
      led_idx_reg   <= '0;
      ch_idx_reg    <= '0;
      led_cnt_reg   <= NUM_LEDS_C;
    end else if (wr_en && !err) begin
      case (apb_paddr_i)
        A_CTRL: begin
          auto_send_reg <= apb_pwdata_i[0];
          irq_en_reg    <= apb_pwdata_i[2];
        end
        A_ADDR: begin
          led_idx_reg <= apb_pwdata_i[7:0];
          ch_idx_reg  <= apb_pwdata_i[11:8];
        end
        A_CWR:  led_idx_reg <= (led_inc >= led_cnt_reg) ? 8'd0 : led_inc[7:0];
        A_LCNT: led_cnt_reg <= apb_pwdata_i[8:0];
        default: ;
      endcase
    end
  end

  // Serialiser. led_reg is driven from the state of the previous cycle, so
  // every pulse and bit period keeps its exact length. When another LED
  // follows, the LOAD cycle replaces the last low cycle of the previous bit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg   <= ST_IDLE;
      cyc_reg     <= '0;
      bit_reg     <= '0;
      led_num_reg <= '0;
      led_reg     <= '0;
      sending_reg <= 1'b0;
      done_reg    <= 1'b0;
      dirty_reg   <= 1'b0;
      int_reg     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) shift_reg[c] <= '0;
    end else begin
      int_reg <= done_reg & irq_en_reg;
      if (wr_en && apb_paddr_i == A_STATUS && apb_pwdata_i[1]) done_reg <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        led_reg[c] <= (state_reg == ST_HIGH) &&
                      (cyc_reg < (shift_reg[c][COLOUR_BITS-1] ? T1H_C : T0H_C));
      case (state_reg)
        ST_IDLE: if (start_frame) begin
          state_reg   <= ST_LOAD;
          led_num_reg <= '0;
        end
        ST_LOAD: begin
          for (int c = 0; c < NUM_CH; c++) shift_reg[c] <= load_val[c];
          sending_reg <= 1'b1;
          bit_reg     <= '0;
          cyc_reg     <= '0;
          state_reg   <= ST_HIGH;
          if (led_num_reg == 8'd0) dirty_reg <= 1'b0;
        end
        ST_HIGH: begin
          cyc_reg <= cyc_reg + 1'b1;
          if (cyc_reg == T1H_C - 1'b1) state_reg <= ST_LOW;
        end
        ST_LOW: begin
          cyc_reg <= cyc_reg + 1'b1;
          if (bit_reg == BIT_IDX_LAST) begin
            if ({1'b0, led_num_reg} + 9'd1 >= led_cnt_reg) begin
              if (cyc_reg == BIT_LAST) begin
                state_reg <= ST_LATCH;
                cyc_reg   <= '0;
              end
            end else if (cyc_reg == BIT_PRELOAD) begin
              state_reg   <= ST_LOAD;
              led_num_reg <= led_num_reg + 8'd1;
            end
          end else if (cyc_reg == BIT_LAST) begin
            state_reg <= ST_HIGH;
            cyc_reg   <= '0;
            bit_reg   <= bit_reg + 1'b1;
            for (int c = 0; c < NUM_CH; c++)
              shift_reg[c] <= {shift_reg[c][COLOUR_BITS-2:0], 1'b0};
          end
        end
        ST_LATCH: begin
          cyc_reg <= cyc_reg + 1'b1;
          if (cyc_reg == LATCH_LAST) begin
            state_reg   <= ST_IDLE;
            done_reg    <= 1'b1;
            sending_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      // A colour write landing on the LED-0 load cycle must still request a
      // frame, so setting dirty takes priority over clearing it.
      if (colour_wr_ok) dirty_reg <= 1'b1;
    end
  end
endmodule
